// File: rtl/fact_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fact_datapath
// Purpose  : Factorial datapath computing n! by nested repeated addition,
//            with loop status flags and a synchronised start pulse.
//            Optional cycle counter enabled by FACT_CYCLE_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fact_datapath #(
  parameter int N_W = 4,
  parameter int R_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_async,
  input  logic [N_W-1:0] n_in,
  input  logic           inicio,
  input  logic           whilen,
  input  logic           whilej,
  input  logic           fine,
  output logic           go_sync,
  output logic           ngt0,
  output logic           jgt1,
  output logic [R_W-1:0] result,
  output logic           done,
  output logic           overflow,
  output logic [15:0]    cycles
);

  logic           r_s1, r_s2, r_s3;
  logic [N_W-1:0] r_n, r_j;
  logic [R_W-1:0] r_acc, r_base, r_result;
  logic           r_done, r_overflow;
  logic [R_W:0]   w_sum;
  logic [N_W-1:0] w_n_dec, w_j_dec;

  // Two-flop synchroniser followed by a rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= go_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign go_sync = r_s2 & ~r_s3;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_base};
  assign w_n_dec = (r_n != '0) ? r_n - N_W'(1) : r_n;
  assign w_j_dec = (r_j != '0) ? r_j - N_W'(1) : r_j;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      r_base     <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (inicio) begin
      r_n        <= n_in;
      r_j        <= '0;
      r_acc      <= R_W'(1);
      r_base     <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (whilen) begin
      r_base <= r_acc;
      r_j    <= r_n;
      r_n    <= w_n_dec;
    end else if (whilej) begin
      r_acc <= w_sum[R_W-1:0];
      r_j   <= w_j_dec;
      if (w_sum[R_W]) begin
        r_overflow <= 1'b1;
      end
    end else if (fine && !r_done) begin
      // Only the first fine after inicio captures; later ones hold.
      r_result <= r_acc;
      r_done   <= 1'b1;
    end
  end

  assign ngt0     = (r_n != '0);
  assign jgt1     = (r_j > N_W'(1));
  assign result   = r_result;
  assign done     = r_done;
  assign overflow = r_overflow;

`ifdef FACT_CYCLE_COUNT_EN
  logic [15:0] r_cycles;

  // The inicio cycle itself is part of the measured span, hence the load of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= 16'h0000;
    end else if (inicio) begin
      r_cycles <= 16'h0001;
    end else if (!r_done && !fine && (r_cycles != 16'hFFFF)) begin
      r_cycles <= r_cycles + 16'h0001;
    end
  end

  assign cycles = r_cycles;
`else
  assign cycles = 16'h0000;
`endif

endmodule
`default_nettype wire
